// File: rtl/fir_stim_master_if.sv
// AXI-stream-style sample link between the stimulus master and the FIR input.
// Ports: tdata/tvalid/tlast driven by the master, tready driven by the slave.
// The master modport is used by fir_stim_master; the slave modport is used by the FIR side.
interface fir_stim_master_if #(
    parameter int DATA_W = 6
);
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/fir_stim_master.sv
// Purpose: on-chip FIR self-stimulus source; emits impulse/step/ramp/LFSR bursts over m_axis.
// Latency: start sampled in cycle t -> first beat valid in t+1; rate_div idle cycles between beats.
// Backpressure: beat (tdata/tlast) held with tvalid high until tready; LFSR/idx advance only on handshake.
// Ports: clk, reset (sync, active high), start, mode[1:0], len[CNT_W], rate_div[DIV_W],
//        m_axis (master modport: tdata, tvalid, tlast out; tready in), busy, done.
// Option: define FIR_STIM_ABORT_EN to add the 'abort' input (early burst termination).
module fir_stim_master #(
    parameter int         DATA_W    = 6,
    parameter int         CNT_W     = 8,
    parameter int         DIV_W     = 8,
    parameter logic [5:0] LFSR_SEED = 6'h2D
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         mode,
    input  logic [CNT_W-1:0]   len,
    input  logic [DIV_W-1:0]   rate_div,
    fir_stim_master_if.master  m_axis,
    output logic               busy,
    output logic               done
`ifdef FIR_STIM_ABORT_EN
    ,
    input  logic               abort
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_DONE} state_t;

    localparam logic [DATA_W-1:0] PEAK = DATA_W'(6'h1F);

    state_t            r_state;
    logic [1:0]        r_mode;
    logic [CNT_W-1:0]  r_len;
    logic [DIV_W-1:0]  r_rate;
    logic [CNT_W-1:0]  r_idx;
    logic [DIV_W-1:0]  r_gap;
    logic [5:0]        r_lfsr;
    logic [DATA_W-1:0] r_tdata;
    logic              r_tvalid;
    logic              r_tlast;
    logic              r_busy;
    logic              r_done;
    logic              r_abort_pend;

    logic              w_hs;
    logic              w_abort;
    logic [CNT_W-1:0]  w_idx_inc;
    logic [5:0]        w_lfsr_shift;

`ifdef FIR_STIM_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    assign w_hs         = r_tvalid & m_axis.tready;
    assign w_idx_inc    = r_idx + CNT_W'(1);
    // Fibonacci x^6 + x^5 + 1: feedback from the two top taps into bit 0.
    assign w_lfsr_shift = {r_lfsr[4:0], r_lfsr[5] ^ r_lfsr[4]};

    assign m_axis.tdata  = r_tdata;
    assign m_axis.tvalid = r_tvalid;
    assign m_axis.tlast  = r_tlast;
    assign busy          = r_busy;
    assign done          = r_done;

    function automatic logic [DATA_W-1:0] f_sample(input logic [1:0]       m,
                                                   input logic [CNT_W-1:0] n,
                                                   input logic [5:0]       l);
        logic [DATA_W-1:0] v;
        case (m)
            2'd0:    v = (n == '0) ? PEAK : '0;
            2'd1:    v = PEAK;
            2'd2:    v = DATA_W'(n[5:0]);
            default: v = DATA_W'(l);
        endcase
        return v;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_mode       <= '0;
            r_len        <= '0;
            r_rate       <= '0;
            r_idx        <= '0;
            r_gap        <= '0;
            r_lfsr       <= LFSR_SEED;
            r_tdata      <= '0;
            r_tvalid     <= 1'b0;
            r_tlast      <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_abort_pend <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done       <= 1'b0;
                    r_abort_pend <= 1'b0;
                    if (start) begin
                        r_mode <= mode;
                        r_len  <= len;
                        r_rate <= rate_div;
                        r_idx  <= '0;
                        r_lfsr <= LFSR_SEED;
                        r_busy <= 1'b1;
                        if (len != '0) begin
                            r_state  <= S_SEND;
                            r_tvalid <= 1'b1;
                            r_tdata  <= f_sample(mode, '0, LFSR_SEED);
                            r_tlast  <= (len == CNT_W'(1));
                        end else begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_SEND: begin
                    // An abort during a stalled beat only takes effect after that beat is accepted.
                    if (w_abort) r_abort_pend <= 1'b1;
                    if (w_hs) begin
                        r_idx  <= w_idx_inc;
                        r_lfsr <= w_lfsr_shift;
                        if (r_tlast || r_abort_pend || w_abort) begin
                            r_state  <= S_DONE;
                            r_tvalid <= 1'b0;
                            r_tlast  <= 1'b0;
                            r_done   <= 1'b1;
                        end else if (r_rate == '0) begin
                            r_tdata <= f_sample(r_mode, w_idx_inc, w_lfsr_shift);
                            r_tlast <= (w_idx_inc == r_len - CNT_W'(1));
                        end else begin
                            r_state  <= S_WAIT;
                            r_tvalid <= 1'b0;
                            r_tlast  <= 1'b0;
                            r_gap    <= DIV_W'(1);
                        end
                    end
                end
                S_WAIT: begin
                    // r_gap counts the idle cycles already spent; idx/LFSR were advanced at the handshake.
                    if (w_abort) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else if (r_gap == r_rate) begin
                        r_state  <= S_SEND;
                        r_tvalid <= 1'b1;
                        r_tdata  <= f_sample(r_mode, r_idx, r_lfsr);
                        r_tlast  <= (r_idx == r_len - CNT_W'(1));
                    end else begin
                        r_gap <= r_gap + DIV_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_stim_master.sv
module tb_fir_stim_master;

    logic       clk;
    logic       reset;
    logic       start;
    logic [1:0] mode;
    logic [7:0] len;
    logic [7:0] rate_div;
    logic       busy;
    logic       done;
`ifdef FIR_STIM_ABORT_EN
    logic       abort;
`endif

    int n_checks;
    int n_fail;

    fir_stim_master_if #(.DATA_W(6)) axis ();

    fir_stim_master dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .mode     (mode),
        .len      (len),
        .rate_div (rate_div),
        .m_axis   (axis),
        .busy     (busy),
        .done     (done)
`ifdef FIR_STIM_ABORT_EN
        ,
        .abort    (abort)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Outputs are observed 1 time unit after the rising edge; inputs are changed at the same point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a burst, then scramble the configuration inputs so latching is exercised.
    task automatic launch(input logic [1:0] m, input logic [7:0] l, input logic [7:0] r);
        mode = m; len = l; rate_div = r; start = 1'b1;
        tick();
        start = 1'b0; mode = ~m; len = 8'hFF; rate_div = 8'h07;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        n_checks++;
        if (axis.tvalid !== 1'b0 || axis.tlast !== 1'b0 || axis.tdata !== 6'h00 ||
            busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got v=%b l=%b d=%h busy=%b done=%b, expected all zero",
                     axis.tvalid, axis.tlast, axis.tdata, busy, done);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_impulse();
        logic [5:0] exp_d [4];
        exp_d = '{6'h1F, 6'h00, 6'h00, 6'h00};
        axis.tready = 1'b1;
        launch(2'd0, 8'd4, 8'd0);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (axis.tvalid !== 1'b1 || axis.tdata !== exp_d[i] || axis.tlast !== (i == 3)) begin
                n_fail++;
                $display("FAIL impulse_beat%0d: got v=%b d=%h l=%b, expected v=1 d=%h l=%b",
                         i, axis.tvalid, axis.tdata, axis.tlast, exp_d[i], (i == 3));
            end
            tick();
        end
        n_checks++;
        if (done !== 1'b1 || axis.tvalid !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL impulse_done: got done=%b v=%b busy=%b, expected 1 0 1", done, axis.tvalid, busy);
        end
        tick();
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL impulse_idle: got done=%b busy=%b, expected 0 0", done, busy);
        end
    endtask

    task automatic test_single_beat();
        axis.tready = 1'b1;
        launch(2'd2, 8'd1, 8'd3);
        n_checks++;
        if (axis.tvalid !== 1'b1 || axis.tdata !== 6'h00 || axis.tlast !== 1'b1) begin
            n_fail++;
            $display("FAIL len1_beat: got v=%b d=%h l=%b, expected 1 00 1", axis.tvalid, axis.tdata, axis.tlast);
        end
        tick();
        n_checks++;
        if (done !== 1'b1 || axis.tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL len1_done: got done=%b v=%b, expected 1 0", done, axis.tvalid);
        end
        tick();
    endtask

    task automatic test_ramp();
        logic [5:0] e;
        axis.tready = 1'b1;
        launch(2'd2, 8'd70, 8'd0);
        for (int i = 0; i < 70; i++) begin
            e = i[5:0];
            n_checks++;
            if (axis.tvalid !== 1'b1 || axis.tdata !== e || axis.tlast !== (i == 69)) begin
                n_fail++;
                $display("FAIL ramp_beat%0d: got v=%b d=%h l=%b, expected v=1 d=%h l=%b",
                         i, axis.tvalid, axis.tdata, axis.tlast, e, (i == 69));
            end
            tick();
        end
        n_checks++;
        if (done !== 1'b1 || axis.tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL ramp_done: got done=%b v=%b, expected 1 0", done, axis.tvalid);
        end
        tick();
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ramp_busy_after: got busy=%b, expected 0", busy);
        end
    endtask

    task automatic test_rate_gap();
        logic exp_v [7];
        exp_v = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        axis.tready = 1'b1;
        launch(2'd1, 8'd3, 8'd2);
        for (int i = 0; i < 7; i++) begin
            n_checks++;
            if (axis.tvalid !== exp_v[i] || (exp_v[i] && axis.tdata !== 6'h1F)) begin
                n_fail++;
                $display("FAIL gap_cycle%0d: got v=%b d=%h, expected v=%b d=1f", i, axis.tvalid, axis.tdata, exp_v[i]);
            end
            if (i == 6) begin
                n_checks++;
                if (axis.tlast !== 1'b1) begin
                    n_fail++;
                    $display("FAIL gap_tlast: got %b, expected 1", axis.tlast);
                end
            end
            tick();
        end
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL gap_done: got %b, expected 1", done);
        end
        tick();
    endtask

    task automatic test_backpressure();
        logic [5:0] exp_d [5];
        exp_d = '{6'h2D, 6'h1B, 6'h37, 6'h2E, 6'h1D};
        axis.tready = 1'b1;
        launch(2'd3, 8'd5, 8'd0);
        for (int b = 0; b < 5; b++) begin
            if (b == 1) begin
                for (int s = 0; s < 3; s++) begin
                    axis.tready = 1'b0;
                    n_checks++;
                    if (axis.tvalid !== 1'b1 || axis.tdata !== exp_d[1] || axis.tlast !== 1'b0) begin
                        n_fail++;
                        $display("FAIL stall%0d: got v=%b d=%h l=%b, expected v=1 d=%h l=0",
                                 s, axis.tvalid, axis.tdata, axis.tlast, exp_d[1]);
                    end
                    tick();
                end
                axis.tready = 1'b1;
            end
            n_checks++;
            if (axis.tvalid !== 1'b1 || axis.tdata !== exp_d[b] || axis.tlast !== (b == 4)) begin
                n_fail++;
                $display("FAIL lfsr_beat%0d: got v=%b d=%h l=%b, expected v=1 d=%h l=%b",
                         b, axis.tvalid, axis.tdata, axis.tlast, exp_d[b], (b == 4));
            end
            tick();
        end
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL lfsr_done: got %b, expected 1", done);
        end
        tick();
    endtask

    task automatic test_zero_len_and_ignore_start();
        int beats;
        int dones;
        axis.tready = 1'b1;
        launch(2'd1, 8'd0, 8'd0);
        n_checks++;
        if (axis.tvalid !== 1'b0 || done !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL len0_done: got v=%b done=%b busy=%b, expected 0 1 1", axis.tvalid, done, busy);
        end
        tick();
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0 || axis.tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL len0_idle: got done=%b busy=%b v=%b, expected 0 0 0", done, busy, axis.tvalid);
        end
        launch(2'd1, 8'd3, 8'd1);
        beats = 0;
        dones = 0;
        mode = 2'd2; len = 8'd8; rate_div = 8'd0; start = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (axis.tvalid && axis.tready) beats++;
            if (done) dones++;
            if (i == 2) start = 1'b0;
            tick();
        end
        n_checks++;
        if (beats != 3 || dones != 1) begin
            n_fail++;
            $display("FAIL start_ignored: got beats=%0d dones=%0d, expected beats=3 dones=1", beats, dones);
        end
    endtask

    task automatic test_reset_mid_burst();
        axis.tready = 1'b1;
        launch(2'd3, 8'd8, 8'd0);
        tick();
        n_checks++;
        if (axis.tvalid !== 1'b1 || axis.tdata !== 6'h1B) begin
            n_fail++;
            $display("FAIL midrst_pre: got v=%b d=%h, expected 1 1b", axis.tvalid, axis.tdata);
        end
        reset = 1'b1;
        tick();
        n_checks++;
        if (axis.tvalid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_abort: got v=%b busy=%b done=%b, expected 0 0 0", axis.tvalid, busy, done);
        end
        reset = 1'b0;
        tick();
        launch(2'd3, 8'd2, 8'd0);
        n_checks++;
        if (axis.tvalid !== 1'b1 || axis.tdata !== 6'h2D || axis.tlast !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_restart0: got v=%b d=%h l=%b, expected 1 2d 0", axis.tvalid, axis.tdata, axis.tlast);
        end
        tick();
        n_checks++;
        if (axis.tvalid !== 1'b1 || axis.tdata !== 6'h1B || axis.tlast !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_restart1: got v=%b d=%h l=%b, expected 1 1b 1", axis.tvalid, axis.tdata, axis.tlast);
        end
        tick();
        tick();
        launch(2'd2, 8'd3, 8'd0);
        tick();
        n_checks++;
        if (axis.tdata !== 6'h01 || axis.tvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL ramp_after_rst: got v=%b d=%h, expected 1 01", axis.tvalid, axis.tdata);
        end
        tick(); tick(); tick();
    endtask

`ifdef FIR_STIM_ABORT_EN
    task automatic test_abort();
        int beats;
        axis.tready = 1'b1;
        launch(2'd1, 8'd5, 8'd3);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_checks++;
        if (done !== 1'b1 || axis.tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_wait_done: got done=%b v=%b, expected 1 0", done, axis.tvalid);
        end
        beats = 0;
        for (int i = 0; i < 8; i++) begin
            if (axis.tvalid) beats++;
            tick();
        end
        n_checks++;
        if (beats != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_no_beats: got beats=%0d busy=%b, expected 0 0", beats, busy);
        end
    endtask
`endif

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        reset       = 1'b1;
        start       = 1'b0;
        mode        = 2'd0;
        len         = 8'd0;
        rate_div    = 8'd0;
        axis.tready = 1'b1;
`ifdef FIR_STIM_ABORT_EN
        abort       = 1'b0;
`endif
        test_reset();
        test_impulse();
        test_single_beat();
        test_ramp();
        test_rate_gap();
        test_backpressure();
        test_zero_len_and_ignore_start();
        test_reset_mid_burst();
`ifdef FIR_STIM_ABORT_EN
        test_abort();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
